// File: rtl/fg_config_sequencer_pkg.sv
// Shared definitions for the foreground configuration sequencer:
// command encodings, scale encoding and offset width.
package fg_config_sequencer_pkg;

    localparam int OFFSET_W = 12;

    localparam logic [1:0] CMD_SCALE    = 2'd0;
    localparam logic [1:0] CMD_OFFSET_X = 2'd1;
    localparam logic [1:0] CMD_OFFSET_Y = 2'd2;
    localparam logic [1:0] CMD_COMMIT   = 2'd3;

    // Encoding consumed by the foreground scale stage.
    typedef enum logic [1:0] {
        SCALE_X1 = 2'd0,
        SCALE_X2 = 2'd1,
        SCALE_X4 = 2'd2,
        SCALE_X8 = 2'd3
    } fg_scale_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } seq_state_e;

endpackage

// File: rtl/fg_offset_slider.sv
// One offset axis: committed target plus the active value that moves toward
// it by at most SLIDE_STEP per frame (or jumps when SLIDE_STEP is 0).
module fg_offset_slider
    import fg_config_sequencer_pkg::*;
#(
    parameter int SLIDE_STEP = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                step,
    input  logic                load,
    input  logic [OFFSET_W-1:0] load_value,
    output logic [OFFSET_W-1:0] active,
    output logic [OFFSET_W-1:0] target
);

    localparam logic [OFFSET_W:0]   STEP_WIDE = (OFFSET_W + 1)'(SLIDE_STEP);
    localparam logic [OFFSET_W-1:0] STEP      = OFFSET_W'(SLIDE_STEP);

    logic [OFFSET_W-1:0]        eff_target;
    logic [OFFSET_W-1:0]        next_active;
    logic signed [OFFSET_W:0]   diff;
    logic [OFFSET_W:0]          abs_diff;

    // A commit and the first slide step share a cycle, so step from the new target.
    always_comb begin
        eff_target  = load ? load_value : target;
        diff        = $signed({eff_target[OFFSET_W-1], eff_target})
                    - $signed({active[OFFSET_W-1], active});
        abs_diff    = diff[OFFSET_W] ? $unsigned(-diff) : $unsigned(diff);
        next_active = eff_target;
        if (SLIDE_STEP != 0 && abs_diff > STEP_WIDE) begin
            if (diff[OFFSET_W]) begin
                next_active = active - STEP;
            end else begin
                next_active = active + STEP;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target <= '0;
            active <= '0;
        end else begin
            if (load) begin
                target <= load_value;
            end
            if (step) begin
                active <= next_active;
            end
        end
    end

endmodule

// File: rtl/fg_config_sequencer.sv
// Shadows foreground scale/offset writes and applies them atomically at the
// next frame start, optionally sliding offsets toward their targets.
module fg_config_sequencer
    import fg_config_sequencer_pkg::*;
#(
    parameter int RESOLUTION_X = 1920,
    parameter int RESOLUTION_Y = 1080,
    parameter int SLIDE_STEP   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_type,
    input  logic [11:0] cmd_data,
    input  logic [10:0] pixel_x,
    input  logic [10:0] pixel_y,
    output logic [1:0]  ctrl_foreground_scale,
    output logic [11:0] fg_offset_x,
    output logic [11:0] fg_offset_y,
    output logic        commit_pending,
    output logic        sliding,
    output logic [15:0] frame_count
);

    seq_state_e          state;
    seq_state_e          state_next;
    logic                alive;
    logic                match_q;
    logic                at_origin;
    logic                frame_start;
    logic                cmd_fire;
    logic                load;
    fg_scale_e           scale_shadow;
    logic [OFFSET_W-1:0] x_shadow;
    logic [OFFSET_W-1:0] y_shadow;
    logic [OFFSET_W-1:0] x_target;
    logic [OFFSET_W-1:0] y_target;

    // A zero-sized raster has no origin, so it never produces a frame start.
    assign at_origin   = (pixel_x == 11'd0) && (pixel_y == 11'd0)
                      && (RESOLUTION_X > 0) && (RESOLUTION_Y > 0);
    assign frame_start = at_origin && !match_q;

    assign cmd_ready      = alive && (state == ST_IDLE);
    assign commit_pending = (state == ST_PENDING);
    assign cmd_fire       = cmd_valid && cmd_ready;
    assign load           = frame_start && (state == ST_PENDING);
    assign sliding        = (fg_offset_x != x_target) || (fg_offset_y != y_target);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (cmd_fire && cmd_type == CMD_COMMIT) state_next = ST_PENDING;
            ST_PENDING: if (frame_start) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // alive keeps cmd_ready low until the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            alive   <= 1'b0;
            match_q <= 1'b0;
        end else begin
            state   <= state_next;
            alive   <= 1'b1;
            match_q <= at_origin;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scale_shadow <= SCALE_X1;
            x_shadow     <= '0;
            y_shadow     <= '0;
        end else if (cmd_fire) begin
            case (cmd_type)
                CMD_SCALE:    scale_shadow <= fg_scale_e'(cmd_data[1:0]);
                CMD_OFFSET_X: x_shadow     <= cmd_data;
                CMD_OFFSET_Y: y_shadow     <= cmd_data;
                default:      ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_foreground_scale <= 2'd0;
            frame_count           <= 16'd0;
        end else if (frame_start) begin
            frame_count <= frame_count + 16'd1;
            if (load) begin
                ctrl_foreground_scale <= scale_shadow;
            end
        end
    end

    fg_offset_slider #(.SLIDE_STEP(SLIDE_STEP)) u_slider_x (
        .clk        (clk),
        .rst        (rst),
        .step       (frame_start),
        .load       (load),
        .load_value (x_shadow),
        .active     (fg_offset_x),
        .target     (x_target)
    );

    fg_offset_slider #(.SLIDE_STEP(SLIDE_STEP)) u_slider_y (
        .clk        (clk),
        .rst        (rst),
        .step       (frame_start),
        .load       (load),
        .load_value (y_shadow),
        .active     (fg_offset_y),
        .target     (y_target)
    );

endmodule

// File: tb/tb_fg_config_sequencer.sv
// Directed bench: a jump instance (SLIDE_STEP 0) and a slide instance
// (SLIDE_STEP 16) receive identical stimulus.
module tb_fg_config_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_type = 2'd0;
    logic [11:0] cmd_data = 12'd0;
    logic [10:0] pixel_x = 11'd5;
    logic [10:0] pixel_y = 11'd5;

    logic        rdy0, pend0, slid0, rdy1, pend1, slid1;
    logic [1:0]  scale0, scale1;
    logic [11:0] x0, y0, x1, y1;
    logic [15:0] fc0, fc1;

    int vectors = 0;
    int errors  = 0;
    int fc_exp  = 0;

    always #5 clk = ~clk;

    fg_config_sequencer #(.RESOLUTION_X(1920), .RESOLUTION_Y(1080), .SLIDE_STEP(0)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy0),
        .cmd_type(cmd_type), .cmd_data(cmd_data), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .ctrl_foreground_scale(scale0), .fg_offset_x(x0), .fg_offset_y(y0),
        .commit_pending(pend0), .sliding(slid0), .frame_count(fc0)
    );

    fg_config_sequencer #(.RESOLUTION_X(1920), .RESOLUTION_Y(1080), .SLIDE_STEP(16)) dut_slide (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy1),
        .cmd_type(cmd_type), .cmd_data(cmd_data), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .ctrl_foreground_scale(scale1), .fg_offset_x(x1), .fg_offset_y(y1),
        .commit_pending(pend1), .sliding(slid1), .frame_count(fc1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one command and waits (bounded) for the handshake.
    task automatic send_cmd(input logic [1:0] t, input logic [11:0] d);
        bit ok = 0;
        cmd_valid = 1'b1;
        cmd_type  = t;
        cmd_data  = d;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (rdy0) ok = 1;
            tick();
        end
        cmd_valid = 1'b0;
        vectors++;
        if (!ok) begin errors++; $display("[TB] FAIL cmd_accept type=%0d got not-accepted want accepted", t); end
    endtask

    // One frame start: a single cycle at the origin, then back into the raster.
    task automatic frame_pulse();
        pixel_x = 11'd0;
        pixel_y = 11'd0;
        tick();
        pixel_x = 11'd5;
        pixel_y = 11'd5;
        tick();
        fc_exp++;
    endtask

    task automatic test_reset();
        tick(); tick();
        vectors++; if (rdy0 !== 1'b0) begin errors++; $display("[TB] FAIL rst_ready got %b want 0", rdy0); end
        vectors++; if ({scale0, x0, y0} !== 26'd0) begin errors++; $display("[TB] FAIL rst_outputs got %h want 0", {scale0, x0, y0}); end
        vectors++; if ({pend0, slid0, fc0} !== 18'd0) begin errors++; $display("[TB] FAIL rst_status got %h want 0", {pend0, slid0, fc0}); end
        rst = 1'b0;
        #1;
        vectors++; if (rdy0 !== 1'b0) begin errors++; $display("[TB] FAIL rst_release_ready got %b want 0", rdy0); end
        tick();
        vectors++; if ({rdy0, rdy1} !== 2'b11) begin errors++; $display("[TB] FAIL ready_after_release got %b want 11", {rdy0, rdy1}); end
        fc_exp = 0;
    endtask

    task automatic test_commit_atomic();
        send_cmd(2'd0, 12'd2);
        send_cmd(2'd1, 12'd100);
        send_cmd(2'd2, 12'hFCE);
        vectors++; if ({scale0, x0, y0} !== 26'd0) begin errors++; $display("[TB] FAIL shadow_isolation got %h want 0", {scale0, x0, y0}); end
        send_cmd(2'd3, 12'd0);
        vectors++; if ({pend0, rdy0} !== 2'b10) begin errors++; $display("[TB] FAIL pending_state got %b want 10", {pend0, rdy0}); end
        tick(); tick(); tick();
        vectors++; if ({scale0, x0, y0} !== 26'd0) begin errors++; $display("[TB] FAIL hold_until_frame got %h want 0", {scale0, x0, y0}); end
        frame_pulse();
        vectors++; if (scale0 !== 2'd2) begin errors++; $display("[TB] FAIL commit_scale got %0d want 2", scale0); end
        vectors++; if (x0 !== 12'd100) begin errors++; $display("[TB] FAIL commit_x got %0d want 100", $signed(x0)); end
        vectors++; if (y0 !== 12'hFCE) begin errors++; $display("[TB] FAIL commit_y got %0d want -50", $signed(y0)); end
        vectors++; if ({pend0, rdy0, slid0} !== 3'b010) begin errors++; $display("[TB] FAIL commit_status got %b want 010", {pend0, rdy0, slid0}); end
        vectors++; if (fc0 !== 16'(fc_exp)) begin errors++; $display("[TB] FAIL commit_frame_count got %0d want %0d", fc0, fc_exp); end
        vectors++; if ({x1, y1} !== {12'd16, 12'hFF0}) begin errors++; $display("[TB] FAIL slide_first_step got %0d,%0d want 16,-16", $signed(x1), $signed(y1)); end
        vectors++; if ({slid1, scale1} !== 3'b110) begin errors++; $display("[TB] FAIL slide_status got %b want 110", {slid1, scale1}); end
    endtask

    task automatic test_back_to_back();
        send_cmd(2'd3, 12'd0);
        cmd_valid = 1'b1;
        cmd_type  = 2'd0;
        cmd_data  = 12'd3;
        for (int i = 0; i < 3; i++) begin
            vectors++; if (rdy0 !== 1'b0) begin errors++; $display("[TB] FAIL blocked_ready cycle %0d got %b want 0", i, rdy0); end
            tick();
        end
        pixel_x = 11'd0;
        pixel_y = 11'd0;
        tick();
        pixel_x = 11'd5;
        pixel_y = 11'd5;
        fc_exp++;
        vectors++; if ({rdy0, pend0, scale0} !== 4'b1010) begin errors++; $display("[TB] FAIL release_after_frame got %b want 1010", {rdy0, pend0, scale0}); end
        vectors++; if ({x1, y1} !== {12'd32, 12'hFE0}) begin errors++; $display("[TB] FAIL slide_second_step got %0d,%0d want 32,-32", $signed(x1), $signed(y1)); end
        tick();
        cmd_valid = 1'b0;
        send_cmd(2'd3, 12'd0);
        frame_pulse();
        vectors++; if (scale0 !== 2'd3) begin errors++; $display("[TB] FAIL held_write_applied got %0d want 3", scale0); end
        vectors++; if (x1 !== 12'd48) begin errors++; $display("[TB] FAIL slide_third_step got %0d want 48", $signed(x1)); end
    endtask

    task automatic test_reset_mid();
        send_cmd(2'd3, 12'd0);
        vectors++; if ({pend1, slid1} !== 2'b11) begin errors++; $display("[TB] FAIL pre_reset_state got %b want 11", {pend1, slid1}); end
        rst = 1'b1;
        #1;
        vectors++; if ({x1, y1, scale1, x0} !== 38'd0) begin errors++; $display("[TB] FAIL async_reset_offsets got %h want 0", {x1, y1, scale1, x0}); end
        vectors++; if ({pend1, slid1, rdy1, fc1} !== 19'd0) begin errors++; $display("[TB] FAIL async_reset_status got %h want 0", {pend1, slid1, rdy1, fc1}); end
        tick();
        rst = 1'b0;
        #1;
        vectors++; if (rdy1 !== 1'b0) begin errors++; $display("[TB] FAIL mid_release_ready got %b want 0", rdy1); end
        tick();
        vectors++; if ({rdy1, pend1, fc1} !== {2'b10, 16'd0}) begin errors++; $display("[TB] FAIL mid_after_release got %h want %h", {rdy1, pend1, fc1}, {2'b10, 16'd0}); end
        fc_exp = 0;
    endtask

    task automatic test_slide_up();
        logic [11:0] exp_x [3];
        logic        exp_s [3];
        exp_x = '{12'd16, 12'd32, 12'd40};
        exp_s = '{1'b1, 1'b1, 1'b0};
        send_cmd(2'd1, 12'd40);
        send_cmd(2'd3, 12'd0);
        for (int i = 0; i < 3; i++) begin
            frame_pulse();
            vectors++; if ({x1, slid1} !== {exp_x[i], exp_s[i]}) begin errors++; $display("[TB] FAIL slide_up frame %0d got x=%0d s=%b want x=%0d s=%b", i, $signed(x1), slid1, $signed(exp_x[i]), exp_s[i]); end
        end
        vectors++; if ({x0, y0, y1, slid0} !== {12'd40, 12'd0, 12'd0, 1'b0}) begin errors++; $display("[TB] FAIL jump_up got x=%0d y=%0d y1=%0d s=%b want 40,0,0,0", $signed(x0), $signed(y0), $signed(y1), slid0); end
        vectors++; if (fc1 !== 16'(fc_exp)) begin errors++; $display("[TB] FAIL slide_frame_count got %0d want %0d", fc1, fc_exp); end
    endtask

    task automatic test_slide_down();
        logic [11:0] exp_x [3];
        logic        exp_s [3];
        exp_x = '{12'd24, 12'd8, 12'hFF8};
        exp_s = '{1'b1, 1'b1, 1'b0};
        send_cmd(2'd1, 12'hFF8);
        send_cmd(2'd3, 12'd0);
        for (int i = 0; i < 3; i++) begin
            frame_pulse();
            vectors++; if ({x1, slid1} !== {exp_x[i], exp_s[i]}) begin errors++; $display("[TB] FAIL slide_down frame %0d got x=%0d s=%b want x=%0d s=%b", i, $signed(x1), slid1, $signed(exp_x[i]), exp_s[i]); end
            if (i == 0) begin
                vectors++; if (x0 !== 12'hFF8) begin errors++; $display("[TB] FAIL jump_down got %0d want -8", $signed(x0)); end
            end
        end
    endtask

    task automatic test_commit_on_frame_start();
        send_cmd(2'd0, 12'd1);
        cmd_valid = 1'b1;
        cmd_type  = 2'd3;
        pixel_x   = 11'd0;
        pixel_y   = 11'd0;
        vectors++; if (rdy0 !== 1'b1) begin errors++; $display("[TB] FAIL same_cycle_ready got %b want 1", rdy0); end
        tick();
        cmd_valid = 1'b0;
        pixel_x   = 11'd5;
        pixel_y   = 11'd5;
        fc_exp++;
        vectors++; if ({pend0, scale0} !== 3'b100) begin errors++; $display("[TB] FAIL same_cycle_deferred got %b want 100", {pend0, scale0}); end
        tick();
        frame_pulse();
        vectors++; if ({pend0, scale0} !== 3'b001) begin errors++; $display("[TB] FAIL same_cycle_next_frame got %b want 001", {pend0, scale0}); end
    endtask

    task automatic test_frame_hold();
        logic [10:0] bx [4];
        logic [10:0] by [4];
        bx = '{11'd0, 11'd5, 11'd1920, 11'd2047};
        by = '{11'd5, 11'd0, 11'd1080, 11'd2047};
        pixel_x = 11'd0;
        pixel_y = 11'd0;
        for (int i = 0; i < 5; i++) tick();
        pixel_x = 11'd5;
        pixel_y = 11'd5;
        tick();
        fc_exp++;
        vectors++; if (fc0 !== 16'(fc_exp)) begin errors++; $display("[TB] FAIL origin_hold_count got %0d want %0d", fc0, fc_exp); end
        for (int i = 0; i < 4; i++) begin
            pixel_x = bx[i];
            pixel_y = by[i];
            tick(); tick();
        end
        pixel_x = 11'd5;
        pixel_y = 11'd5;
        tick();
        vectors++; if ({fc0, fc1} !== {16'(fc_exp), 16'(fc_exp)}) begin errors++; $display("[TB] FAIL blanking_no_frame got %0d,%0d want %0d", fc0, fc1, fc_exp); end
        vectors++; if ({x1, scale0} !== {12'hFF8, 2'd1}) begin errors++; $display("[TB] FAIL blanking_stable got %h want %h", {x1, scale0}, {12'hFF8, 2'd1}); end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog timeout got running want finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_commit_atomic();
        test_back_to_back();
        test_reset_mid();
        test_slide_up();
        test_slide_down();
        test_commit_on_frame_start();
        test_frame_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
